serial_adder_ctrl: RTL and testbench

//   Bit-serial adder controller. Time-shares one existing 1-bit fadder cell
//   (ports s, c, in[0:2]) to add two WIDTH-bit operands, LSB first, one bit per clock.

---
 rtl/serial_adder_ctrl.sv | 94 +++++++++
 tb/tb_serial_adder_ctrl.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder controller: streams two WIDTH-bit operands LSB first through
// a single 1-bit full-adder cell, with start/busy/done handshake.
module serial_adder_ctrl #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic             carry_q;
    logic [CW-1:0]    cnt;

    logic [0:2] fa_in;
    logic       fa_s_c;
    logic       fa_c_c;

    // Shared full-adder cell: s/c of the current bit pair plus running carry
    always_comb begin
        fa_in  = {a_sh[0], b_sh[0], carry_q};
        fa_s_c = fa_in[0] ^ fa_in[1] ^ fa_in[2];
        fa_c_c = (fa_in[0] & fa_in[1]) | (fa_in[0] & fa_in[2]) | (fa_in[1] & fa_in[2]);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            busy    <= 1'b0;
            done    <= 1'b0;
            sum     <= '0;
            cout    <= 1'b0;
            a_sh    <= '0;
            b_sh    <= '0;
            carry_q <= 1'b0;
            cnt     <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    // Accept a new add from IDLE or straight out of DONE (back-to-back)
                    if (start) begin
                        state   <= RUN;
                        busy    <= 1'b1;
                        done    <= 1'b0;
                        a_sh    <= a;
                        b_sh    <= b;
                        carry_q <= cin;
                        cnt     <= '0;
                    end else begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        done  <= 1'b0;
                    end
                end
                RUN: begin
                    a_sh    <= a_sh >> 1;
                    b_sh    <= b_sh >> 1;
                    sum     <= {fa_s_c, sum[WIDTH-1:1]};
                    carry_q <= fa_c_c;
                    cnt     <= cnt + CW'(1);
                    if (cnt == CW'(WIDTH - 1)) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        cout  <= fa_c_c;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Directed self-checking bench for serial_adder_ctrl (WIDTH=8).
module tb_serial_adder_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic       busy;
    logic       done;
    logic [7:0] sum;
    logic       cout;

    int checks = 0;
    int errors = 0;

    serial_adder_ctrl #(.WIDTH(8)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .cin   (cin),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout)
    );

    always #5 clk = ~clk;

    // Issue one add, wait (bounded) for done; returns busy cycle count
    task automatic run_add(input logic [7:0] ta, input logic [7:0] tb_v, input logic tc,
                           output int busy_cnt, output bit got_done);
        @(negedge clk);
        a = ta; b = tb_v; cin = tc; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        busy_cnt = 0;
        got_done = 1'b0;
        for (int i = 0; i < 20 && !got_done; i++) begin
            if (busy) busy_cnt++;
            if (done) got_done = 1'b1;
            else @(negedge clk);
        end
    endtask

    task automatic check_add(input string name, input logic [7:0] ta, input logic [7:0] tb_v,
                             input logic tc, input logic [7:0] exp_sum, input logic exp_cout);
        int  bc;
        bit  gd;
        run_add(ta, tb_v, tc, bc, gd);
        checks++;
        if (!gd) begin
            errors++;
            $display("FAIL %s_done_timeout: done=%b required=1", name, done);
        end
        checks++;
        if (bc !== 8) begin
            errors++;
            $display("FAIL %s_busy_cycles: got %0d required 8", name, bc);
        end
        checks++;
        if (sum !== exp_sum || cout !== exp_cout) begin
            errors++;
            $display("FAIL %s_result: sum=%h cout=%b required sum=%h cout=%b",
                     name, sum, cout, exp_sum, exp_cout);
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b0 || busy !== 1'b0 || sum !== exp_sum) begin
            errors++;
            $display("FAIL %s_after: done=%b busy=%b sum=%h required 0 0 %h",
                     name, done, busy, sum, exp_sum);
        end
    endtask

    task automatic test_reset;
        int dcnt;
        rst = 1'b1; start = 1'b0; a = '0; b = '0; cin = 1'b0;
        #3;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || sum !== 8'h00 || cout !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle: busy=%b done=%b sum=%h cout=%b required 0 0 00 0",
                     busy, done, sum, cout);
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        a = 8'hFF; b = 8'hFF; cin = 1'b1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL reset_pre_busy: busy=%b required 1", busy);
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || sum !== 8'h00 || cout !== 1'b0) begin
            errors++;
            $display("FAIL reset_midrun: busy=%b done=%b sum=%h cout=%b required 0 0 00 0",
                     busy, done, sum, cout);
        end
        @(negedge clk);
        rst = 1'b0;
        dcnt = 0;
        repeat (12) begin
            @(negedge clk);
            if (done) dcnt++;
        end
        checks++;
        if (dcnt !== 0) begin
            errors++;
            $display("FAIL reset_no_done: done pulses=%0d required 0", dcnt);
        end
        check_add("reset_recover", 8'h0F, 8'h01, 1'b0, 8'h10, 1'b0);
    endtask

    task automatic test_basic;
        check_add("basic", 8'h0F, 8'h01, 1'b0, 8'h10, 1'b0);
    endtask

    task automatic test_wrap;
        check_add("wrap", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1);
    endtask

    task automatic test_alternating;
        check_add("alt", 8'hAA, 8'h55, 1'b1, 8'h00, 1'b1);
        check_add("zero", 8'h00, 8'h00, 1'b0, 8'h00, 1'b0);
    endtask

    task automatic test_ignore_start;
        int dcnt;
        int both;
        dcnt = 0;
        both = 0;
        for (int i = 0; i < 24; i++) begin
            @(negedge clk);
            if (i == 0) begin a = 8'h03; b = 8'h04; cin = 1'b0; start = 1'b1; end
            if (i == 1) start = 1'b0;
            if (i == 3) begin a = 8'h01; b = 8'h01; start = 1'b1; end
            if (i == 4) begin start = 1'b0; a = 8'h00; b = 8'h00; end
            if (done) dcnt++;
            if (done && busy) both++;
        end
        checks++;
        if (dcnt !== 1) begin
            errors++;
            $display("FAIL ignore_done_count: got %0d required 1", dcnt);
        end
        checks++;
        if (sum !== 8'h07 || cout !== 1'b0) begin
            errors++;
            $display("FAIL ignore_result: sum=%h cout=%b required 07 0", sum, cout);
        end
        checks++;
        if (both !== 0) begin
            errors++;
            $display("FAIL ignore_busy_done_overlap: cycles=%0d required 0", both);
        end
    endtask

    task automatic test_back_to_back(input logic [7:0] ta, input logic [7:0] tb_v,
                                     input logic tc);
        logic [8:0] ref9;
        int last_done;
        int dcnt;
        int gap_err;
        int res_err;
        ref9 = {1'b0, ta} + {1'b0, tb_v} + 9'(tc);
        last_done = -1;
        dcnt = 0;
        gap_err = 0;
        res_err = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (i == 0) begin a = ta; b = tb_v; cin = tc; start = 1'b1; end
            if (done) begin
                dcnt++;
                if (last_done >= 0 && (i - last_done) != 9) gap_err++;
                if (sum !== ref9[7:0] || cout !== ref9[8]) res_err++;
                last_done = i;
            end
            if (i >= 1 && (busy === done)) gap_err++;
        end
        start = 1'b0;
        checks++;
        if (dcnt !== 4) begin
            errors++;
            $display("FAIL b2b_done_count: got %0d required 4", dcnt);
        end
        checks++;
        if (gap_err !== 0) begin
            errors++;
            $display("FAIL b2b_spacing: bad cycles=%0d required 0", gap_err);
        end
        checks++;
        if (res_err !== 0) begin
            errors++;
            $display("FAIL b2b_result: bad results=%0d last sum=%h cout=%b required sum=%h cout=%b",
                     res_err, sum, cout, ref9[7:0], ref9[8]);
        end
        for (int i = 0; i < 12 && !done; i++) @(negedge clk);
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL b2b_drain: busy=%b done=%b required 0 0", busy, done);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_wrap();
        test_alternating();
        test_ignore_start();
        test_back_to_back(8'h10, 8'h20, 1'b0);
        test_back_to_back(8'hF0, 8'h20, 1'b1);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
